// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared types and width helpers for the vector register file sequencer
package vrf_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 10;
  localparam int MVL_DEF   = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} vrf_state_e;
  typedef enum logic {GNT_FU, GNT_LD} vrf_gnt_e;

  // Register number width: the BRAM address is {reg, element index}
  function automatic int reg_w(input int depth, input int mvl);
    return depth - $clog2(mvl);
  endfunction

  function automatic int idx_w(input int mvl);
    return $clog2(mvl);
  endfunction

  // Vector length needs one extra bit to represent MVL itself
  function automatic int vl_w(input int mvl);
    return $clog2(mvl) + 1;
  endfunction

endpackage

// File: rtl/vrf_wr_arbiter.sv
// rtl/vrf_wr_arbiter.sv - two-way round-robin arbiter and mux for the BRAM write port
module vrf_wr_arbiter
  import vrf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fu_req,
  input  logic [DEPTH-1:0] fu_addr,
  input  logic [WIDTH-1:0] fu_data,
  input  logic             ld_req,
  input  logic [DEPTH-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             fu_gnt,
  output logic             ld_gnt,
  output logic             w_en,
  output logic [DEPTH-1:0] addr_write,
  output logic [WIDTH-1:0] wdata
);

  vrf_gnt_e rr_ptr;
  vrf_gnt_e rr_ptr_nxt;

  // Grant selection: a lone requester always wins, a tie goes to the rr_ptr side
  always_comb begin
    fu_gnt     = 1'b0;
    ld_gnt     = 1'b0;
    rr_ptr_nxt = rr_ptr;
    if (fu_req && ld_req) begin
      if (rr_ptr == GNT_FU) fu_gnt = 1'b1;
      else                  ld_gnt = 1'b1;
    end else begin
      fu_gnt = fu_req;
      ld_gnt = ld_req;
    end
    if (fu_gnt)      rr_ptr_nxt = GNT_LD;
    else if (ld_gnt) rr_ptr_nxt = GNT_FU;
    w_en       = fu_gnt | ld_gnt;
    addr_write = fu_gnt ? fu_addr : ld_addr;
    wdata      = fu_gnt ? fu_data : ld_data;
  end

  // Priority pointer moves to the side that did not win the last grant
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= GNT_FU;
    else     rr_ptr <= rr_ptr_nxt;
  end

endmodule

// File: rtl/vrf_access_sequencer.sv
// rtl/vrf_access_sequencer.sv - streams vs1/vs2 operand pairs to the FU and retires vd writes
module vrf_access_sequencer
  import vrf_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int MVL   = MVL_DEF,
  localparam int REG_W = reg_w(DEPTH, MVL),
  localparam int IDX_W = idx_w(MVL),
  localparam int VL_W  = vl_w(MVL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [REG_W-1:0]   req_vs1,
  input  logic [REG_W-1:0]   req_vs2,
  input  logic [REG_W-1:0]   req_vd,
  input  logic [VL_W-1:0]    req_vl,
  output logic               done,
  output logic [2*DEPTH-1:0] addr_read,
  input  logic [2*WIDTH-1:0] rd_i,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [IDX_W-1:0]   op_idx,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [IDX_W-1:0]   res_idx,
  input  logic [WIDTH-1:0]   res_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [DEPTH-1:0]   ld_addr,
  input  logic [WIDTH-1:0]   ld_data,
  output logic               w_en,
  output logic [DEPTH-1:0]   addr_write,
  output logic [WIDTH-1:0]   wdata
);

  vrf_state_e       state, state_nxt;
  logic [REG_W-1:0] vs1_q, vs2_q, vd_q;
  logic [VL_W-1:0]  vl_q, rd_cnt, wr_cnt;
  logic             zero_done_q;
  logic             accept, op_fire, last_pair, fu_req, fu_gnt;
  logic [DEPTH-1:0] fu_addr;

  // MVL is a power of two, so reg*MVL+idx is just the concatenation {reg, idx}
  assign addr_read = {vs2_q, rd_cnt[IDX_W-1:0], vs1_q, rd_cnt[IDX_W-1:0]};
  assign op_a      = rd_i[WIDTH-1:0];
  assign op_b      = rd_i[2*WIDTH-1:WIDTH];
  assign op_idx    = rd_cnt[IDX_W-1:0];
  assign op_fire   = op_valid && op_ready;
  assign last_pair = (rd_cnt + VL_W'(1)) == vl_q;
  assign fu_req    = res_valid && (state != IDLE);
  assign fu_addr   = {vd_q, res_idx};
  assign res_ready = fu_gnt;

  // Next-state and handshake outputs; a zero-length instruction retires from IDLE
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    op_valid  = 1'b0;
    accept    = 1'b0;
    done      = zero_done_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_vl != '0) state_nxt = READ;
        end
      end
      READ: begin
        op_valid = 1'b1;
        if (op_ready && last_pair) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (wr_cnt == vl_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, latched instruction fields and element counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      vl_q        <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      zero_done_q <= accept && (req_vl == '0);
      if (accept) begin
        vs1_q  <= req_vs1;
        vs2_q  <= req_vs2;
        vd_q   <= req_vd;
        vl_q   <= req_vl;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (op_fire) rd_cnt <= rd_cnt + VL_W'(1);
        if (fu_gnt)  wr_cnt <= wr_cnt + VL_W'(1);
      end
    end
  end

  vrf_wr_arbiter #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_wr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .fu_req    (fu_req),
    .fu_addr   (fu_addr),
    .fu_data   (res_data),
    .ld_req    (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .fu_gnt    (fu_gnt),
    .ld_gnt    (ld_ready),
    .w_en      (w_en),
    .addr_write(addr_write),
    .wdata     (wdata)
  );

endmodule

// File: tb/tb_vrf_access_sequencer.sv
// tb/tb_vrf_access_sequencer.sv - directed self-checking bench for vrf_access_sequencer
module tb_vrf_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_vs1, req_vs2, req_vd;
  logic [5:0]  req_vl;
  logic        done;
  logic [19:0] addr_read;
  logic [63:0] rd_i;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_idx;
  logic        res_valid, res_ready;
  logic [4:0]  res_idx;
  logic [31:0] res_data;
  logic        ld_valid, ld_ready;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        w_en;
  logic [9:0]  addr_write;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // BRAM content model: each word carries its own address
  function automatic logic [31:0] bram_f(input logic [9:0] a);
    return {22'h3037A, a};
  endfunction

  assign rd_i = {bram_f(addr_read[19:10]), bram_f(addr_read[9:0])};

  vrf_access_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd), .req_vl(req_vl),
    .done(done), .addr_read(addr_read), .rd_i(rd_i),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_idx(op_idx),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .w_en(w_en), .addr_write(addr_write), .wdata(wdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_op_valid"}, op_valid, 1'b0);
    check({tag, "_w_en"}, w_en, 1'b0);
    check({tag, "_res_ready"}, res_ready, 1'b0);
    check({tag, "_ld_ready"}, ld_ready, 1'b0);
    check({tag, "_req_ready"}, req_ready, 1'b1);
  endtask

  // Issue one instruction and play the FU: in-order echo one cycle after each
  // accepted pair, or (ooo) results 3,0,2,1 once every pair has been read
  task automatic run_instr(input string tag, input logic [4:0] vs1, input logic [4:0] vs2,
                           input logic [4:0] vd, input logic [5:0] vl,
                           input bit stall, input bit ooo);
    int          rd_exp = 0;
    int          wr_seen = 0;
    int          ndone = 0;
    int          last_wr = -10;
    int          ooo_pos = 0;
    int          order[4] = '{3, 0, 2, 1};
    bit          pend = 0;
    bit          hs;
    logic [4:0]  pend_idx = '0;
    logic [31:0] pend_data = '0;
    logic [4:0]  ridx;
    req_vs1 = vs1; req_vs2 = vs2; req_vd = vd; req_vl = vl; req_valid = 1'b1;
    #1;
    check({tag, "_req_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && ndone == 0; cyc++) begin
      op_ready  = !stall || (cyc % 2 == 0);
      res_valid = 1'b0;
      if (!ooo && pend) begin
        res_valid = 1'b1; res_idx = pend_idx; res_data = pend_data;
      end
      if (ooo && rd_exp == int'(vl) && ooo_pos < int'(vl)) begin
        res_valid = 1'b1;
        res_idx   = 5'(order[ooo_pos]);
        res_data  = 32'h5000 + 32'(order[ooo_pos]);
      end
      #1;
      hs   = 1'b0;
      ridx = rd_exp[4:0];
      if (op_valid) begin
        if (rd_exp >= int'(vl)) check({tag, "_extra_pair"}, op_valid, 1'b0);
        check({tag, "_addr_vs1"}, addr_read[9:0], {vs1, ridx});
        check({tag, "_addr_vs2"}, addr_read[19:10], {vs2, ridx});
        check({tag, "_op_idx"}, op_idx, ridx);
        check({tag, "_op_a"}, op_a, bram_f({vs1, ridx}));
        check({tag, "_op_b"}, op_b, bram_f({vs2, ridx}));
        hs = op_ready;
      end
      if (res_valid) begin
        check({tag, "_res_ready"}, res_ready, 1'b1);
        check({tag, "_w_en"}, w_en, 1'b1);
        check({tag, "_addr_write"}, addr_write, {vd, res_idx});
        check({tag, "_wdata"}, wdata, res_data);
        wr_seen++;
        last_wr = cyc;
        if (ooo) ooo_pos++;
      end
      if (done) begin
        ndone++;
        check({tag, "_done_reads"}, rd_exp, vl);
        check({tag, "_done_writes"}, wr_seen, vl);
        check({tag, "_done_latency"}, cyc, last_wr + 1);
      end
      pend = hs;
      if (hs) begin
        pend_idx  = ridx;
        pend_data = op_a + op_b;
        rd_exp++;
      end
      tick();
    end
    check({tag, "_done_seen"}, ndone, 1);
    res_valid = 1'b0;
    op_ready  = 1'b0;
    #1;
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_vl = '0;
    op_ready = 1'b0; res_valid = 1'b0; res_idx = '0; res_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Arbiter tie: FU and LD both requesting while an instruction is stalled in READ
    req_vs1 = 5'd1; req_vs2 = 5'd2; req_vd = 5'd3; req_vl = 6'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1; res_idx = 5'(k); res_data = 32'h100 + 32'(k);
      ld_valid  = 1'b1; ld_addr = 10'd900 + 10'(k); ld_data = 32'h200 + 32'(k);
      #1;
      check("arb_w_en", w_en, 1'b1);
      check("arb_res_ready", res_ready, (k % 2 == 0));
      check("arb_ld_ready", ld_ready, (k % 2 == 1));
      if (k % 2 == 0) begin
        check("arb_fu_addr", addr_write, {5'd3, 5'(k)});
        check("arb_fu_data", wdata, 32'h100 + 32'(k));
      end else begin
        check("arb_ld_addr", addr_write, 10'd900 + 10'(k));
        check("arb_ld_data", wdata, 32'h200 + 32'(k));
      end
      tick();
    end
    res_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_idle_outputs("arb_reset");
    rst = 1'b0;
    tick();

    // vl=8 streaming with next-cycle echo; writes land at 64..71
    run_instr("stream8", 5'd0, 5'd1, 5'd2, 6'd8, 1'b0, 1'b0);
    // vl=4 with op_ready alternating
    run_instr("stall4", 5'd5, 5'd6, 5'd7, 6'd4, 1'b1, 1'b0);
    // vl=4 with results returned out of order
    run_instr("ooo4", 5'd8, 5'd9, 5'd10, 6'd4, 1'b0, 1'b1);

    // vl=0 retires from IDLE one cycle after acceptance
    req_vs1 = 5'd1; req_vs2 = 5'd1; req_vd = 5'd1; req_vl = 6'd0; req_valid = 1'b1;
    #1;
    check("vl0_req_ready", req_ready, 1'b1);
    check("vl0_done_early", done, 1'b0);
    tick();
    req_valid = 1'b0;
    #1;
    check("vl0_done", done, 1'b1);
    check("vl0_op_valid", op_valid, 1'b0);
    check("vl0_req_ready_after", req_ready, 1'b1);
    tick();
    check("vl0_done_pulse", done, 1'b0);
    check("vl0_op_valid_after", op_valid, 1'b0);

    // Reset two cycles into a vl=16 instruction aborts it silently
    req_vs1 = 5'd3; req_vs2 = 5'd4; req_vd = 5'd5; req_vl = 6'd16; req_valid = 1'b1;
    op_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    op_ready = 1'b0;
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("midrst_no_done", done, 1'b0);
      check("midrst_no_op", op_valid, 1'b0);
    end
    run_instr("post_rst2", 5'd11, 5'd12, 5'd13, 6'd2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
